// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared types for the rv32i core and its program loader.
//   XLEN / word_t / reg_idx_t : core datapath typedefs
//   loader_state_e            : program_loader FSM states
//   len_in_range()            : legal program length check (1..depth)
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0]      reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } loader_state_e;

  // A load request is legal only for 1..depth words.
  function automatic logic len_in_range(input int unsigned len_words,
                                        input int unsigned depth_words);
    return (len_words != 0) && (len_words <= depth_words);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Upstream word stream plus instruction memory write port of the loader.
//   s_valid/s_data/s_ready       : valid/ready word stream into the loader
//   mem_we/mem_addr/mem_wdata    : instruction memory write port
// Modports:
//   slave  : the loader (consumes the stream, drives the memory port)
//   master : the upstream source / memory side
// ---------------------------------------------------------------------------
interface program_loader_if #(
  parameter int N  = 32,
  parameter int AW = 10
);
  logic          s_valid;
  logic [N-1:0]  s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Streams a program image into instruction memory while holding the rv32i
// core in reset, then releases the core once the final write has landed.
// Ports:
//   clk         : single clock, rising edge
//   reset       : synchronous active-high reset
//   start       : one-cycle load request
//   len         : words to load, sampled only when start is accepted
//   bus         : stream in / memory write out (program_loader_if.slave)
//   cpu_reset_n : active-low core reset, low while loading
//   done        : load complete, core running
//   err         : sticky, last start request was rejected
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a legal start; core held in reset
// LOAD  | accepting words, one registered memory write per transfer
// FLUSH | final write on the memory port; core still held
// RUN   | core released; a legal start reloads
// ---------------------------------------------------------------------------
module program_loader
  import rv32i_pkg::*;
#(
  parameter  int n     = 32,
  parameter  int depth = 1024,
  localparam int AW    = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AW:0]          len,
  program_loader_if.slave      bus,
  output logic                 cpu_reset_n,
  output logic                 done,
  output logic                 err
);

  loader_state_e state_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [AW:0]   len_q;
  logic          len_ok;
  logic          xfer;
  logic          s_ready_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [n-1:0]  mem_wdata_q;
  logic          cpu_reset_n_q;
  logic          done_q;
  logic          err_q;

  always_comb begin
    len_ok = len_in_range(32'(len), depth);
    xfer   = bus.s_valid && s_ready_q;
    cnt_d  = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      s_ready_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_reset_n_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse following each transfer.
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_q   <= LOAD;
              cnt_q     <= '0;
              len_q     <= len;
              err_q     <= 1'b0;
              s_ready_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cnt_q[AW-1:0];
            mem_wdata_q <= bus.s_data;
            cnt_q       <= cnt_d;
            // Drop ready together with the last transfer so no extra
            // word can be taken before the FSM leaves LOAD.
            if (cnt_d == len_q) begin
              state_q   <= FLUSH;
              s_ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // The final write is on the port this cycle; release the core
          // only after it.
          state_q       <= RUN;
          cpu_reset_n_q <= 1'b1;
          done_q        <= 1'b1;
        end
        RUN: begin
          if (start) begin
            if (len_ok) begin
              state_q       <= LOAD;
              cnt_q         <= '0;
              len_q         <= len;
              err_q         <= 1'b0;
              s_ready_q     <= 1'b1;
              cpu_reset_n_q <= 1'b0;
              done_q        <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset_n   = cpu_reset_n_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int N     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic          cpu_reset_n;
  logic          done;
  logic          err;

  program_loader_if #(.N(N), .AW(AW)) bus ();

  program_loader #(.n(N), .depth(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .bus         (bus.slave),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;

  logic [AW+N-1:0] sb_q[$];
  logic [AW+N-1:0] sb_item;
  int              exp_addr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else
      n_pass++;
  endtask

  // Scoreboard monitor: every write must match the next expected word.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      n_wr++;
      if (sb_q.size() == 0) begin
        chk("unexpected_we", 64'(bus.mem_addr), 64'hFFFF);
      end else begin
        sb_item = sb_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(sb_item[AW+N-1:N]));
        chk("wr_data", 64'(bus.mem_wdata), 64'(sb_item[N-1:0]));
      end
      if (cpu_reset_n === 1'b1)
        chk("core_released_during_we", 64'(cpu_reset_n), 64'd0);
    end
  end

  task automatic do_start(input int l);
    start = 1'b1;
    len   = (AW+1)'(l);
    exp_addr = 0;
    @(posedge clk); #1;
    start = 1'b0;
    len   = (AW+1)'($urandom);
  endtask

  task automatic send_word(input logic [N-1:0] d);
    int budget;
    budget = 50;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(negedge clk);
    while (bus.s_ready !== 1'b1 && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (budget == 0) begin
      chk("s_ready_timeout", 64'd0, 64'd1);
    end else begin
      sb_q.push_back({AW'(exp_addr), d});
      exp_addr++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int b;
    b = budget;
    @(negedge clk);
    while (done !== 1'b1 && b > 0) begin
      b--;
      @(negedge clk);
    end
    chk("done_reached", 64'(done), 64'd1);
    chk("cpu_released", 64'(cpu_reset_n), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"},   64'(bus.s_ready),   64'd0);
    chk({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
    chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_cpu_rst_n"}, 64'(cpu_reset_n),   64'd0);
    chk({tag, "_done"},      64'(done),          64'd0);
    chk({tag, "_err"},       64'(err),           64'd0);
  endtask

  logic [N-1:0] prog3 [3];
  int           wr_base;

  initial begin
    prog3[0] = 32'h00500093;
    prog3[1] = 32'h00A00113;
    prog3[2] = 32'h002081B3;
    reset = 1'b1; start = 1'b0; len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    exp_addr = 0;

    // Reset two cycles, then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;

    // Three-word program, back to back, exact release timing.
    wr_base = n_wr;
    do_start(3);
    for (int i = 0; i < 3; i++) send_word(prog3[i]);
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("l3_last_we",    64'(bus.mem_we),  64'd1);
    chk("l3_ready_low",  64'(bus.s_ready), 64'd0);
    chk("l3_held",       64'(cpu_reset_n), 64'd0);
    chk("l3_not_done",   64'(done),        64'd0);
    @(negedge clk);
    chk("l3_done",       64'(done),        64'd1);
    chk("l3_released",   64'(cpu_reset_n), 64'd1);
    chk("l3_wr_count",   64'(n_wr - wr_base), 64'd3);
    @(posedge clk); #1;

    // Four words with gaps; a start with new len in LOAD must be ignored.
    wr_base = n_wr;
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      send_word($urandom);
      bus.s_valid = 1'b0;
      if (i == 1) begin
        start = 1'b1;
        len   = (AW+1)'(2);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(20);
    chk("gap_wr_count", 64'(n_wr - wr_base), 64'd4);
    chk("gap_sb_empty", 64'(sb_q.size()),    64'd0);

    // Rejected lengths from IDLE.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_base = n_wr;
    do_start(0);
    @(negedge clk);
    chk("len0_err",      64'(err),         64'd1);
    chk("len0_ready",    64'(bus.s_ready), 64'd0);
    chk("len0_held",     64'(cpu_reset_n), 64'd0);
    @(posedge clk); #1;
    do_start(DEPTH + 1);
    repeat (3) @(negedge clk);
    chk("len1025_err",   64'(err),         64'd1);
    chk("len1025_ready", 64'(bus.s_ready), 64'd0);
    chk("len1025_held",  64'(cpu_reset_n), 64'd0);
    chk("bad_len_no_we", 64'(n_wr - wr_base), 64'd0);
    @(posedge clk); #1;
    // A legal start clears err.
    do_start(1);
    @(negedge clk);
    chk("err_cleared",   64'(err),         64'd0);
    chk("len1_ready",    64'(bus.s_ready), 64'd1);
    @(posedge clk); #1;
    send_word($urandom);
    bus.s_valid = 1'b0;
    wait_done(10);

    // Reset after 2 of 5 words, word 3 still offered during reset.
    do_start(5);
    send_word($urandom);
    send_word($urandom);
    bus.s_valid = 1'b1;
    bus.s_data  = $urandom;
    reset = 1'b1;
    start = 1'b1;
    len   = (AW+1)'(1);
    @(posedge clk); #1;
    wr_base = n_wr;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; bus.s_valid = 1'b0;
    chk("midrst_no_we", 64'(n_wr - wr_base), 64'd0);
    wr_base = n_wr;
    do_start(1);
    send_word($urandom);
    bus.s_valid = 1'b0;
    wait_done(10);
    chk("midrst_len1_wr", 64'(n_wr - wr_base), 64'd1);

    // In RUN: illegal len keeps RUN with err, legal len reloads.
    do_start(0);
    @(negedge clk);
    chk("run_bad_err",  64'(err),         64'd1);
    chk("run_bad_done", 64'(done),        64'd1);
    chk("run_bad_rel",  64'(cpu_reset_n), 64'd1);
    @(posedge clk); #1;
    wr_base = n_wr;
    do_start(2);
    @(negedge clk);
    chk("reload_held",  64'(cpu_reset_n), 64'd0);
    chk("reload_ndone", 64'(done),        64'd0);
    chk("reload_err",   64'(err),         64'd0);
    @(posedge clk); #1;
    send_word($urandom);
    send_word($urandom);
    bus.s_valid = 1'b0;
    wait_done(10);
    chk("reload_wr",    64'(n_wr - wr_base), 64'd2);

    // Full-depth load: addresses 0..depth-1, no wrap, no extra word.
    wr_base = n_wr;
    do_start(DEPTH);
    for (int i = 0; i < DEPTH; i++) send_word($urandom);
    bus.s_valid = 1'b1;
    bus.s_data  = $urandom;
    @(negedge clk);
    chk("full_ready_low", 64'(bus.s_ready), 64'd0);
    chk("full_last_addr", 64'(bus.mem_addr), 64'(DEPTH - 1));
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    wait_done(10);
    chk("full_wr_count", 64'(n_wr - wr_base), 64'(DEPTH));
    chk("final_sb_empty", 64'(sb_q.size()),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter n, default 32, instruction/data word width in bits.
REQ-002 SHALL have parameter depth, default 1024, instruction memory size in words; AW = $clog2(depth).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port len  input  AW+1  number of words to load, sampled only in the cycle start is accepted.
REQ-007 SHALL have port s_valid  input  1  upstream word valid.
REQ-008 SHALL have port s_data  input  n  upstream instruction word.
REQ-009 SHALL have port s_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction memory write enable.
REQ-011 SHALL have port mem_addr  output  AW  instruction memory word address.
REQ-012 SHALL have port mem_wdata  output  n  instruction memory write data.
REQ-013 SHALL have port cpu_reset_n  output  1  active-low reset to the rv32i_top core; low holds the core.
REQ-014 SHALL have port done  output  1  load complete; core released.
REQ-015 SHALL have port err  output  1  sticky: last start request was rejected.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FLUSH, RUN.
REQ-017 IDLE: s_ready=0, cpu_reset_n=0; start with 1<=len<=depth -> LOAD, word counter cnt=0, err cleared.
REQ-018 IDLE: start with len=0 or len>depth -> stay IDLE, err=1 from next cycle.
REQ-019 LOAD: s_ready=1; a transfer occurs when s_valid && s_ready.
REQ-020 On each transfer the loader SHALL register mem_we=1, mem_addr=cnt[AW-1:0], mem_wdata=s_data for exactly the following cycle (write latency 1), and increment cnt.
REQ-021 mem_we SHALL be 0 in every cycle not following a transfer; s_valid without transfer produces no write.
REQ-022 On the transfer making cnt equal len, FSM SHALL go to FLUSH; s_ready SHALL be 0 from that next cycle.
REQ-023 FLUSH (one cycle, carrying the final mem_we) -> RUN.
REQ-024 RUN: cpu_reset_n=1, done=1, s_ready=0; cpu_reset_n SHALL rise no earlier than the cycle after the last mem_we.
REQ-025 start in LOAD or FLUSH SHALL be ignored; len changes there SHALL have no effect.
REQ-026 start in RUN with valid len SHALL re-enter LOAD with cnt=0, driving cpu_reset_n=0 and done=0 from the next cycle; invalid len in RUN SHALL set err and keep RUN.
REQ-027 len=depth SHALL write addresses 0..depth-1 with no wrap; cnt SHALL never exceed len.

Reset
REQ-028 While reset=1 at a clock edge: state=IDLE, cnt=0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, done=0, err=0.
REQ-029 Reset mid-LOAD SHALL abort the load with no further mem_we; partially written words remain in memory.
REQ-030 reset SHALL take priority over start and any transfer in the same cycle.

Structure
REQ-031 State enum (IDLE, LOAD, FLUSH, RUN) SHALL live in shared package rv32i_pkg alongside the core's typedefs.
REQ-032 No sub-module; FSM, counter and write register in one module, instantiated ahead of rv32i_top whose reset_n is driven by cpu_reset_n.

Verification
REQ-033 reset=1 two cycles, then idle -> all outputs 0, cpu_reset_n=0.
REQ-034 start, len=3, words 0x00500093,0x00A00113,0x002081B3 back-to-back -> mem_we at addrs 0,1,2 one cycle after each, done=1 and cpu_reset_n=1 the cycle after addr 2 write.
REQ-035 len=4 with s_valid toggled 1,0,1,0,... -> exactly 4 writes at addrs 0..3, no write in gap cycles.
REQ-036 start with len=0, then len=1025 -> err=1, state IDLE, no mem_we, cpu_reset_n=0.
REQ-037 reset asserted after 2 of 5 words -> mem_we=0 next cycle, all outputs at reset values; new start len=1 loads addr 0 only.
REQ-038 In RUN, start len=2 -> cpu_reset_n=0 next cycle, 2 writes to addrs 0,1, RUN re-entered.
